// File: rtl/coin_pkg.sv
// Shared types and constants for the coin acceptor front end.
package coin_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    NICKEL  = 2'd1,
    DIME    = 2'd2,
    QUARTER = 2'd3
  } coin_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } emit_state_t;

  localparam int CH_NICKEL  = 0;
  localparam int CH_DIME    = 1;
  localparam int CH_QUARTER = 2;

  // Output bit order is {quarter, dime, nickel}, matching the channel indices.
  function automatic logic [2:0] coin_onehot(input coin_t c);
    case (c)
      NICKEL:  coin_onehot = 3'b001;
      DIME:    coin_onehot = 3'b010;
      QUARTER: coin_onehot = 3'b100;
      default: coin_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser, debouncer and rising-edge event.
// Optional per-channel jam timer when COIN_ACCEPTOR_JAM_DETECT_EN is defined.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic rise_o,
  output logic jam_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || JAM_CYCLES < 1) begin : g_bad_param
    $error("coin_debounce: DEBOUNCE_CYCLES and JAM_CYCLES must be >= 1");
  end

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          rise_q;
  logic [DW-1:0] cnt_q;

  // The event pulse is registered on the same edge the stable level rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync2_q;
        rise_q   <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + DW'(1);
      end
    end
  end

  assign rise_o = rise_q;

`ifdef COIN_ACCEPTOR_JAM_DETECT_EN
  localparam int JW = $clog2(JAM_CYCLES + 1);

  logic [JW-1:0] jam_cnt_q;
  logic          jam_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jam_cnt_q <= '0;
      jam_q     <= 1'b0;
    end else if (!stable_q) begin
      jam_cnt_q <= '0;
      jam_q     <= 1'b0;
    end else if (jam_cnt_q != JW'(JAM_CYCLES)) begin
      jam_cnt_q <= jam_cnt_q + JW'(1);
      if (jam_cnt_q == JW'(JAM_CYCLES - 1)) begin
        jam_q <= 1'b1;
      end
    end
  end

  assign jam_o = jam_q;
`else
  assign jam_o = 1'b0;
`endif

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front end: debounced events -> pending bits -> FIFO -> gapped one-hot pulses.
// Jam detection is compiled in with COIN_ACCEPTOR_JAM_DETECT_EN.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int JAM_CYCLES      = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          raw_nickel,
  input  logic                          raw_dime,
  input  logic                          raw_quarter,
  input  logic                          enable,
  input  logic                          clr_lost,
  output logic                          nickel,
  output logic                          dime,
  output logic                          quarter,
  output logic                          coin_lost,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    jam
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || GAP_CYCLES < 1 ||
      JAM_CYCLES < 1) begin : g_bad_param
    $error("coin_acceptor: illegal parameter combination");
  end

  logic [2:0] raw_w;
  logic [2:0] rise_w;
  logic [2:0] jam_w;

  assign raw_w = {raw_quarter, raw_dime, raw_nickel};

  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .JAM_CYCLES     (JAM_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (raw_w[ch]),
      .rise_o(rise_w[ch]),
      .jam_o (jam_w[ch])
    );
  end

  logic [2:0]    pend_q, pend_d, drain;
  logic          lost_set, coin_lost_q, wr_en, pop;
  coin_t         wr_code;
  coin_t         mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q;
  emit_state_t   state_q;
  logic [GW-1:0] gap_cnt_q;
  logic [2:0]    pulse_q;

  // A pending bit that is neither drained nor empty when a new event lands loses that event.
  always_comb begin
    drain   = 3'b000;
    wr_code = NONE;
    if (fifo_cnt_q != CW'(FIFO_DEPTH)) begin
      if (pend_q[CH_QUARTER]) begin
        drain[CH_QUARTER] = 1'b1;
        wr_code           = QUARTER;
      end else if (pend_q[CH_DIME]) begin
        drain[CH_DIME] = 1'b1;
        wr_code        = DIME;
      end else if (pend_q[CH_NICKEL]) begin
        drain[CH_NICKEL] = 1'b1;
        wr_code          = NICKEL;
      end
    end
    pend_d   = (pend_q & ~drain) | rise_w;
    lost_set = |(rise_w & pend_q & ~drain);
    wr_en    = |drain;
  end

  // The last GAP cycle may pop directly so pulses sit exactly GAP_CYCLES+1 apart.
  assign pop = (fifo_cnt_q != '0) && enable && (jam_w == 3'b000) &&
               ((state_q == IDLE) ||
                ((state_q == GAP) && (gap_cnt_q == GW'(GAP_CYCLES - 1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 3'b000;
      coin_lost_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      if (lost_set) begin
        coin_lost_q <= 1'b1;
      end else if (clr_lost) begin
        coin_lost_q <= 1'b0;
      end
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      pulse_q   <= 3'b000;
    end else begin
      pulse_q <= 3'b000;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= PULSE;
            pulse_q <= coin_onehot(mem_q[rd_ptr_q]);
          end
        end
        PULSE: begin
          state_q   <= GAP;
          gap_cnt_q <= '0;
        end
        GAP: begin
          if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
            if (pop) begin
              state_q <= PULSE;
              pulse_q <= coin_onehot(mem_q[rd_ptr_q]);
            end else begin
              state_q <= IDLE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nickel     = pulse_q[CH_NICKEL];
  assign dime       = pulse_q[CH_DIME];
  assign quarter    = pulse_q[CH_QUARTER];
  assign coin_lost  = coin_lost_q;
  assign fifo_count = fifo_cnt_q;
  assign jam        = jam_w;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus random sensor traffic
// compared every cycle against a transaction-level model (queue of coins, pop schedule).
module tb_coin_acceptor;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int JAMC  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       raw_nickel, raw_dime, raw_quarter;
  logic       enable, clr_lost;
  logic       nickel, dime, quarter, coin_lost;
  logic [2:0] fifo_count;
  logic [2:0] jam;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP),
    .JAM_CYCLES     (JAMC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_nickel (raw_nickel),
    .raw_dime   (raw_dime),
    .raw_quarter(raw_quarter),
    .enable     (enable),
    .clr_lost   (clr_lost),
    .nickel     (nickel),
    .dime       (dime),
    .quarter    (quarter),
    .coin_lost  (coin_lost),
    .fifo_count (fifo_count),
    .jam        (jam)
  );

  always #5 clk = ~clk;

  int compareCount = 0;
  int failCount    = 0;
  int negCount     = 0;
  int nickelSeen, dimeSeen, quarterSeen, firstDimeNeg, markNeg;

  // Reference model state: coins are channel indices 0=nickel 1=dime 2=quarter.
  int          fifoQ[$];
  int          edgeNo = 0;
  int          earliestPop;
  int          highEdges[3];
  logic [2:0]  d1, d2, mStab, mPend, mRiseDly, mPulse, mJam;
  logic [DEB-1:0] win[3];
  bit          mLost;

  always @(posedge clk or negedge rst_n) begin
    int   oldSize, drainCh, popped;
    bit   popNow, lostNow, allDiffer;
    logic [2:0] rawNow, newRise;
    if (!rst_n) begin
      fifoQ.delete();
      earliestPop = 0;
      d1 = '0; d2 = '0; mStab = '0; mPend = '0; mRiseDly = '0; mPulse = '0; mJam = '0;
      mLost = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        win[ch] = '0;
        highEdges[ch] = 0;
      end
    end else begin
      rawNow  = {raw_quarter, raw_dime, raw_nickel};
      oldSize = fifoQ.size();
      popNow  = (oldSize > 0) && enable && (mJam == 3'b000) && (edgeNo >= earliestPop);
      drainCh = -1;
      if (oldSize < DEPTH) begin
        for (int ch = 2; ch >= 0; ch--) begin
          if (mPend[ch] && drainCh < 0) drainCh = ch;
        end
      end
      mPulse = '0;
      if (popNow) begin
        popped = fifoQ.pop_front();
        mPulse[popped] = 1'b1;
        earliestPop = edgeNo + GAP + 1;
      end
      if (drainCh >= 0) begin
        fifoQ.push_back(drainCh);
        mPend[drainCh] = 1'b0;
      end
      lostNow = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        if (mRiseDly[ch]) begin
          if (mPend[ch]) lostNow = 1'b1;
          mPend[ch] = 1'b1;
        end
      end
      if (lostNow) mLost = 1'b1;
      else if (clr_lost) mLost = 1'b0;
`ifdef COIN_ACCEPTOR_JAM_DETECT_EN
      for (int ch = 0; ch < 3; ch++) begin
        if (mStab[ch]) begin
          if (highEdges[ch] < JAMC) highEdges[ch]++;
          mJam[ch] = (highEdges[ch] >= JAMC);
        end else begin
          highEdges[ch] = 0;
          mJam[ch] = 1'b0;
        end
      end
`endif
      // A level is accepted once the last DEB synced samples all disagree with it.
      newRise = '0;
      for (int ch = 0; ch < 3; ch++) begin
        win[ch] = (win[ch] << 1) | DEB'(d2[ch]);
        allDiffer = mStab[ch] ? (win[ch] == '0) : (win[ch] == '1);
        if (allDiffer) begin
          mStab[ch]   = ~mStab[ch];
          newRise[ch] = mStab[ch];
        end
      end
      mRiseDly = newRise;
      d2 = d1;
      d1 = rawNow;
      edgeNo++;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] rawV, input logic en, input logic clr,
                               input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      negCount++;
      checkOutput("pulse", {quarter, dime, nickel}, mPulse);
      checkOutput("fifoCount", fifo_count, fifoQ.size());
      checkOutput("coinLost", coin_lost, mLost);
      checkOutput("jam", jam, mJam);
      if (nickel) nickelSeen++;
      if (quarter) quarterSeen++;
      if (dime) begin
        dimeSeen++;
        if (firstDimeNeg == 0) firstDimeNeg = negCount;
      end
      {raw_quarter, raw_dime, raw_nickel} = rawV;
      enable   = en;
      clr_lost = clr;
    end
  endtask

  task automatic clearTally();
    nickelSeen = 0; dimeSeen = 0; quarterSeen = 0; firstDimeNeg = 0;
  endtask

  initial begin
    logic [2:0] rawR;
    rst_n = 1'b0;
    {raw_quarter, raw_dime, raw_nickel} = 3'b000;
    enable = 1'b1;
    clr_lost = 1'b0;
    clearTally();
    repeat (3) @(negedge clk);
    checkOutput("resetPulse", {quarter, dime, nickel}, 0);
    checkOutput("resetCount", fifo_count, 0);
    checkOutput("resetLost", coin_lost, 0);
    checkOutput("resetJam", jam, 0);
    rst_n = 1'b1;
    applyStimulus(3'b000, 1'b1, 1'b0, 4);

    $display("[TB] single dime");
    clearTally();
    markNeg = negCount + 1;
    applyStimulus(3'b010, 1'b1, 1'b0, 20);
    applyStimulus(3'b000, 1'b1, 1'b0, 20);
    checkOutput("dimeCount", dimeSeen, 1);
    checkOutput("dimeLatency", firstDimeNeg - markNeg, DEB + 5);
    checkOutput("dimeDrained", fifo_count, 0);

    $display("[TB] quarter glitch");
    clearTally();
    applyStimulus(3'b100, 1'b1, 1'b0, 3);
    applyStimulus(3'b000, 1'b1, 1'b0, 20);
    checkOutput("glitchPulses", quarterSeen, 0);

    $display("[TB] simultaneous coins");
    clearTally();
    applyStimulus(3'b111, 1'b1, 1'b0, 12);
    applyStimulus(3'b000, 1'b1, 1'b0, 25);
    checkOutput("simulNickel", nickelSeen, 1);
    checkOutput("simulDime", dimeSeen, 1);
    checkOutput("simulQuarter", quarterSeen, 1);
    checkOutput("simulLost", coin_lost, 0);

    $display("[TB] overflow with enable low");
    clearTally();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(3'b001, 1'b0, 1'b0, 8);
      applyStimulus(3'b000, 1'b0, 1'b0, 8);
    end
    checkOutput("fullCount", fifo_count, DEPTH);
    checkOutput("overflowLost", coin_lost, 1);
    applyStimulus(3'b000, 1'b1, 1'b0, 30);
    checkOutput("overflowNickels", nickelSeen, 5);
    applyStimulus(3'b000, 1'b1, 1'b1, 1);
    applyStimulus(3'b000, 1'b1, 1'b0, 2);
    checkOutput("lostCleared", coin_lost, 0);

    $display("[TB] reset with coins queued");
    applyStimulus(3'b001, 1'b0, 1'b0, 8);
    applyStimulus(3'b010, 1'b0, 1'b0, 8);
    applyStimulus(3'b100, 1'b0, 1'b0, 8);
    applyStimulus(3'b000, 1'b0, 1'b0, 8);
    checkOutput("queuedBeforeReset", fifo_count, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetPulse", {quarter, dime, nickel}, 0);
    checkOutput("midResetCount", fifo_count, 0);
    applyStimulus(3'b000, 1'b1, 1'b0, 3);
    rst_n = 1'b1;
    clearTally();
    applyStimulus(3'b000, 1'b1, 1'b0, 30);
    checkOutput("afterResetPulses", nickelSeen + dimeSeen + quarterSeen, 0);

`ifdef COIN_ACCEPTOR_JAM_DETECT_EN
    $display("[TB] jam on dime");
    clearTally();
    applyStimulus(3'b010, 1'b1, 1'b0, 14);
    applyStimulus(3'b011, 1'b1, 1'b0, 8);
    applyStimulus(3'b010, 1'b1, 1'b0, 18);
    checkOutput("jamDimePulse", dimeSeen, 1);
    checkOutput("jamFlag", jam, 3'b010);
    checkOutput("jamWithheld", nickelSeen, 0);
    applyStimulus(3'b000, 1'b1, 1'b0, 30);
    checkOutput("jamCleared", jam, 0);
    checkOutput("jamNickelAfter", nickelSeen, 1);
`endif

    $display("[TB] random traffic");
    rawR = 3'b000;
    for (int n = 0; n < 2500; n++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if ($urandom_range(0, 11) == 0) rawR[ch] = ~rawR[ch];
      end
      applyStimulus(rawR, ($urandom_range(0, 9) != 0), ($urandom_range(0, 31) == 0), 1);
    end
    applyStimulus(3'b000, 1'b1, 1'b0, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
